// File: rtl/uart_pkg.sv
// Shared constants and types for the UART blocks: default RX FIFO geometry,
// the line-terminator byte and the per-cycle FIFO decision record.
package uart_pkg;

  localparam int         UART_FIFO_DEPTH = 32;
  localparam logic [7:0] UART_EOL_CHAR   = 8'h0A;
  localparam int         UART_DATA_W     = 8;

  // Per-cycle FIFO decisions, grouped so checkers can bind to one signal.
  typedef struct packed {
    logic push;
    logic pop;
    logic drop;
    logic push_eol;
    logic pop_eol;
  } fifo_op_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for the RX FIFO: synchronous write, registered read.
// The read register resets to zero, while the array itself is never reset.
module uart_fifo_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-first: a same-address write in this cycle is not seen until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: buffers bytes, counts stored line
// terminators and flags bytes dropped while full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int         DEPTH    = UART_FIFO_DEPTH,
  parameter logic [7:0] EOL_CHAR = UART_EOL_CHAR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             uart_data,
  input  logic                   byte_received,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] line_count,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: byte_received pushes with no backpressure (dropped when full
  // and no pop coincides); rd_en pops when non-empty, and rd_valid marks the
  // byte on rd_data exactly one cycle later. rd_en while empty is ignored.

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DEPTH-1:0] eol_flag;
  fifo_op_t         op;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_comb begin
    op          = '0;
    op.pop      = rd_en && !empty;
    op.push     = byte_received && (!full || op.pop);
    op.drop     = byte_received && full && !op.pop;
    op.push_eol = op.push && (uart_data == EOL_CHAR);
    op.pop_eol  = op.pop && eol_flag[rd_ptr];
  end

  // One terminator bit per slot so line_count can drop in the pop cycle
  // itself, before the byte leaves the RAM's read register.
  always_ff @(posedge clk) begin
    if (op.push) begin
      eol_flag[wr_ptr] <= (uart_data == EOL_CHAR);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      line_count <= '0;
      overflow   <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= op.pop;
      if (op.push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (op.pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({op.push, op.pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({op.push_eol, op.pop_eol})
        2'b10:   line_count <= line_count + CW'(1);
        2'b01:   line_count <= line_count - CW'(1);
        default: line_count <= line_count;
      endcase
      // A drop wins over a coincident clear so the loss is never hidden.
      if (op.drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (op.push),
    .wr_addr (wr_ptr),
    .wr_data (uart_data),
    .re      (op.pop),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus a randomized run, all
// checked against a queue-based model of the FIFO contents and flags.
module tb_uart_rx_fifo;

  localparam int         DEPTH = 32;
  localparam logic [7:0] EOL   = 8'h0A;
  localparam int         CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic [7:0]    uart_data;
  logic          byte_received;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [CW-1:0] line_count;
  logic          overflow;
  logic          clear_overflow;

  uart_rx_fifo #(
    .DEPTH    (DEPTH),
    .EOL_CHAR (EOL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .uart_data      (uart_data),
    .byte_received  (byte_received),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .line_count     (line_count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [7:0] exp_q[$];
  logic       exp_ovf;
  logic [7:0] exp_data;
  logic       exp_valid;
  int         n_cmp;
  int         n_bad;

  function automatic int eol_in_q();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i] == EOL) n++;
    return n;
  endfunction

  // Driver: one clock of stimulus, model updated from the FIFO rules.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    logic pop;
    logic full_m;
    uart_data      = d;
    byte_received  = wr;
    rd_en          = rd;
    clear_overflow = clr;
    pop    = rd && (exp_q.size() > 0);
    full_m = (exp_q.size() == DEPTH);
    exp_valid = pop;
    if (pop) exp_data = exp_q.pop_front();
    if (wr && (!full_m || pop)) exp_q.push_back(d);
    if (wr && full_m && !pop) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    byte_received  = 1'b0;
    rd_en          = 1'b0;
    clear_overflow = 1'b0;
  endtask

  // Reset with other inputs active to show that reset overrides them.
  task automatic do_reset(input logic rd);
    reset          = 1'b1;
    byte_received  = 1'b1;
    uart_data      = EOL;
    rd_en          = rd;
    clear_overflow = 1'b0;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    byte_received = 1'b0;
    rd_en         = 1'b0;
    exp_q.delete();
    exp_ovf   = 1'b0;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
  endtask

  task automatic fill_to_full();
    while (exp_q.size() < DEPTH) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", empty, full);
    end
    n_cmp++;
    if (count !== '0 || line_count !== '0) begin
      n_bad++; $display("FAIL reset_counts: count=%0d line=%0d want 0 0", count, line_count);
    end
    n_cmp++;
    if (overflow !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_out: ovf=%b valid=%b data=%h want 0 0 00", overflow, rd_valid, rd_data);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [3];
    bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h0A;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, bytes[i], 1'b0, 1'b0);
    n_cmp++;
    if (count !== CW'(3) || line_count !== CW'(1)) begin
      n_bad++; $display("FAIL basic_fill: count=%0d line=%0d want 3 1", count, line_count);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== bytes[i]) begin
        n_bad++; $display("FAIL basic_pop%0d: valid=%b data=%h want 1 %h", i, rd_valid, rd_data, bytes[i]);
      end
      n_cmp++;
      if (line_count !== CW'(i == 2 ? 0 : 1)) begin
        n_bad++; $display("FAIL basic_line%0d: line=%0d want %0d", i, line_count, (i == 2 ? 0 : 1));
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h0A) begin
      n_bad++; $display("FAIL basic_end: empty=%b valid=%b data=%h want 1 0 0a", empty, rd_valid, rd_data);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] extra;
    do_reset(1'b0);
    fill_to_full();
    n_cmp++;
    if (full !== 1'b1 || overflow !== 1'b0 || count !== CW'(DEPTH)) begin
      n_bad++; $display("FAIL ovf_full: full=%b ovf=%b count=%0d want 1 0 %0d", full, overflow, count, DEPTH);
    end
    extra = 8'hEE;
    step(1'b1, extra, 1'b0, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1 || count !== CW'(DEPTH)) begin
      n_bad++; $display("FAIL ovf_drop: ovf=%b count=%0d want 1 %0d", overflow, count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== exp_data) begin
        n_bad++; $display("FAIL ovf_pop%0d: valid=%b data=%h want 1 %h", i, rd_valid, rd_data, exp_data);
      end
    end
    n_cmp++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_drained: empty=%b ovf=%b want 1 1", empty, overflow);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [7:0] x;
    do_reset(1'b0);
    fill_to_full();
    x = 8'h5A;
    step(1'b1, x, 1'b1, 1'b0);
    n_cmp++;
    if (count !== CW'(DEPTH) || overflow !== 1'b0 || rd_valid !== 1'b1 || rd_data !== exp_data) begin
      n_bad++; $display("FAIL simul: count=%0d ovf=%b valid=%b data=%h want %0d 0 1 %h",
                        count, overflow, rd_valid, rd_data, DEPTH, exp_data);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (rd_data !== x || empty !== 1'b1) begin
      n_bad++; $display("FAIL simul_last: data=%h empty=%b want %h 1", rd_data, empty, x);
    end
  endtask

  task automatic test_empty_pop();
    do_reset(1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b0 || count !== '0 || rd_data !== 8'h00 || empty !== 1'b1) begin
      n_bad++; $display("FAIL empty_pop: valid=%b count=%0d data=%h want 0 0 00", rd_valid, count, rd_data);
    end
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h77 || count !== '0) begin
      n_bad++; $display("FAIL empty_after: valid=%b data=%h count=%0d want 1 77 0", rd_valid, rd_data, count);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 43; i++) begin
        step(i < 40, 8'($urandom_range(0, 255)), i >= 3, 1'b0);
        if (i >= 3) begin
          n_cmp++;
          if (rd_valid !== 1'b1 || rd_data !== exp_data) begin
            n_bad++; $display("FAIL wrap_r%0d_%0d: valid=%b data=%h want 1 %h", r, i, rd_valid, rd_data, exp_data);
          end
        end
      end
      n_cmp++;
      if (count !== '0 || empty !== 1'b1) begin
        n_bad++; $display("FAIL wrap_end%0d: count=%0d empty=%b want 0 1", r, count, empty);
      end
    end
  endtask

  task automatic test_clear_and_reset();
    do_reset(1'b0);
    fill_to_full();
    step(1'b1, 8'h99, 1'b0, 1'b1);
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++; $display("FAIL clr_vs_drop: ovf=%b want 1", overflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL clr_alone: ovf=%b want 0", overflow);
    end
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, (i % 2 == 0) ? EOL : 8'h30, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    do_reset(1'b1);
    n_cmp++;
    if (count !== '0 || line_count !== '0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: count=%0d line=%0d empty=%b valid=%b want 0 0 1 0",
                        count, line_count, empty, rd_valid);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_bad++; $display("FAIL post_reset: valid=%b data=%h want 0 00", rd_valid, rd_data);
    end
  endtask

  task automatic test_random();
    int         wp;
    int         rp;
    logic [7:0] d;
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      case ((i / 100) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 50; rp = 50; end
        default: begin wp = 20; rp = 80; end
      endcase
      d = ($urandom_range(0, 3) == 0) ? EOL : 8'($urandom_range(0, 255));
      step($urandom_range(1, 100) <= wp, d, $urandom_range(1, 100) <= rp,
           $urandom_range(0, 19) == 0);
      n_cmp++;
      if (rd_valid !== exp_valid || rd_data !== exp_data) begin
        n_bad++; $display("FAIL rnd_out%0d: valid=%b data=%h want %b %h", i, rd_valid, rd_data, exp_valid, exp_data);
      end
      n_cmp++;
      if (count !== CW'(exp_q.size()) || line_count !== CW'(eol_in_q())) begin
        n_bad++; $display("FAIL rnd_cnt%0d: count=%0d line=%0d want %0d %0d", i, count, line_count,
                          exp_q.size(), eol_in_q());
      end
      n_cmp++;
      if (overflow !== exp_ovf || empty !== (exp_q.size() == 0) || full !== (exp_q.size() == DEPTH)) begin
        n_bad++; $display("FAIL rnd_flags%0d: ovf=%b empty=%b full=%b want %b %b %b", i, overflow, empty, full,
                          exp_ovf, exp_q.size() == 0, exp_q.size() == DEPTH);
      end
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b0;
    uart_data      = 8'h00;
    byte_received  = 1'b0;
    rd_en          = 1'b0;
    clear_overflow = 1'b0;
    exp_ovf        = 1'b0;
    exp_data       = 8'h00;
    exp_valid      = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_simultaneous();
    test_empty_pop();
    test_wrap();
    test_clear_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

endmodule
